mor1kx_except_ctrl_marocchino: RTL and testbench
================================================

Name: mor1kx_except_ctrl_marocchino

Overview:
Writeback-side exception/RFE controller for the MAROCCHINO pipeline. Consumes the registered exception, RFE, PC and delay-slot outputs of the writeback mux and prioritises pending exceptions. It snapshots EPCR/EEAR/ESR write data, drives the pipeline flush fed back to the writeback mux and earlier stages, and redirects fetch to the exception vector or the RFE return address through a request/acknowledge handshake.

Parameters:
OPTION_OPERAND_WIDTH, 32, PC/address/data width
OPTION_EXCEPT_BASE, 32'h0, base added to fixed OR1K vector offsets

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
wb_except_ibus_err_i  in  1  instruction bus error
wb_except_ipagefault_i  in  1  instruction page fault
wb_except_itlb_miss_i  in  1  ITLB miss
wb_except_ibus_align_i  in  1  instruction misalignment
wb_except_illegal_i  in  1  illegal instruction
wb_except_syscall_i  in  1  l.sys
wb_except_trap_i  in  1  l.trap
wb_except_dbus_i  in  1  data bus error
wb_except_dpagefault_i  in  1  data page fault
wb_except_dtlb_miss_i  in  1  DTLB miss
wb_except_align_i  in  1  data misalignment
wb_excepts_en_i  in  1  qualifies all wb_except_* inputs
wb_op_rfe_i  in  1  l.rfe at writeback
pc_wb_i  in  OPTION_OPERAND_WIDTH  PC of the writeback instruction
wb_delay_slot_i  in  1  writeback instruction is in a delay slot
wb_lsu_adr_i  in  OPTION_OPERAND_WIDTH  effective address of the faulting load/store
sr_i  in  16  current SR
epcr_i  in  OPTION_OPERAND_WIDTH  current EPCR (RFE target)
fetch_ack_i  in  1  fetch accepted the redirect
pipeline_flush_o  out  1  flush pulse
fetch_redirect_o  out  1  redirect request
fetch_target_o  out  OPTION_OPERAND_WIDTH  redirect address
epcr_we_o  out  1  EPCR write strobe
epcr_dat_o  out  OPTION_OPERAND_WIDTH  EPCR data
eear_we_o  out  1  EEAR write strobe
eear_dat_o  out  OPTION_OPERAND_WIDTH  EEAR data
esr_we_o  out  1  ESR write strobe (ESR <= sr_i)
sr_except_o  out  1  SR exception-entry strobe (SM=1, IEE=TEE=0; applied by SPR unit)
sr_restore_o  out  1  SR <= ESR strobe (RFE)
busy_o  out  1  FSM not IDLE; stalls padv_wb

Behaviour:
- Reset: FSM=IDLE; all outputs 0, including fetch_target_o, epcr_dat_o and eear_dat_o. rst_n low mid-operation aborts immediately to IDLE; no strobes are issued.
- except_any = wb_excepts_en_i & OR(all 11 wb_except_*). Exception inputs with wb_excepts_en_i=0 are ignored.
- Fixed priority, high to low: ibus_err 0x200, itlb_miss 0xA00, ipagefault 0x400, ibus_align 0x600, illegal 0x700, dbus_align 0x600, dtlb_miss 0x900, dpagefault 0x300, syscall 0xC00, trap 0xE00, dbus_err 0x200.
- Vector = OPTION_EXCEPT_BASE + offset (modulo 2^OPTION_OPERAND_WIDTH).
- EPCR: delay slot -> pc_wb_i-4; else syscall -> pc_wb_i+4; else pc_wb_i. Arithmetic is modulo width.
- EEAR: data exceptions (dbus_align, dtlb, dpagefault, dbus_err) -> wb_lsu_adr_i. All others -> pc_wb_i.
- FSM states: IDLE, FLUSH, REDIRECT.
- IDLE:
  - except_any -> FLUSH. Latch vector, EPCR and EEAR data.
  - else wb_op_rfe_i -> FLUSH. Latch target=epcr_i.
  - Exception and RFE in the same cycle: exception wins; the RFE is discarded.
- FLUSH (exactly one cycle):
  - pipeline_flush_o=1.
  - Exception: epcr_we_o, eear_we_o, esr_we_o and sr_except_o all pulse 1.
  - RFE: only sr_restore_o pulses.
  - Next state: REDIRECT.
- REDIRECT:
  - fetch_redirect_o=1; fetch_target_o is held stable.
  - fetch_ack_i=1 -> IDLE next cycle, with fetch_redirect_o=0 that cycle.
  - fetch_ack_i is ignored outside REDIRECT.
- Exception and RFE inputs arriving in FLUSH/REDIRECT are ignored; the pipeline is being flushed.
- busy_o = (state != IDLE).
- Detection-to-flush latency: 1 cycle. Minimum event-to-IDLE: 3 cycles with an immediate ack.
- All strobes are single-cycle pulses, registered outputs, and never asserted in IDLE.

Test Plan:
- Illegal at pc_wb_i=0x1000, no delay slot, en=1 -> next cycle flush=1, epcr_dat=0x1000, eear_dat=0x1000, esr_we=1, sr_except=1; then redirect=1, target=0x700 until ack.
- Syscall at 0x2000 -> epcr_dat=0x2004, target=0xC00. Same with delay_slot=1 -> epcr_dat=0x1FFC.
- dtlb_miss + dbus_err together, wb_lsu_adr_i=0xDEAD0000 -> target=0x900, eear_dat=0xDEAD0000, a single flush pulse.
- RFE with epcr_i=0x3000 -> flush=1, sr_restore=1, epcr_we=eear_we=0, target=0x3000. RFE together with trap -> target=0xE00, sr_restore=0.
- Hold fetch_ack_i=0 for 5 cycles in REDIRECT -> redirect and target stable, busy=1, new exceptions ignored; ack -> IDLE next cycle.
- rst_n low during REDIRECT -> all outputs 0 asynchronously; after release, an exception with en=0 produces no response.

Source files
------------

// File: rtl/mor1kx_except_ctrl_marocchino.sv
// Writeback-side exception/RFE controller: prioritises exceptions, snapshots EPCR/EEAR,
// flushes the pipeline and redirects fetch through a request/acknowledge handshake.
module mor1kx_except_ctrl_marocchino #(
  parameter int unsigned                     OPTION_OPERAND_WIDTH = 32,
  parameter logic [OPTION_OPERAND_WIDTH-1:0] OPTION_EXCEPT_BASE   = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wb_except_ibus_err_i,
  input  logic                            wb_except_ipagefault_i,
  input  logic                            wb_except_itlb_miss_i,
  input  logic                            wb_except_ibus_align_i,
  input  logic                            wb_except_illegal_i,
  input  logic                            wb_except_syscall_i,
  input  logic                            wb_except_trap_i,
  input  logic                            wb_except_dbus_i,
  input  logic                            wb_except_dpagefault_i,
  input  logic                            wb_except_dtlb_miss_i,
  input  logic                            wb_except_align_i,
  input  logic                            wb_excepts_en_i,
  input  logic                            wb_op_rfe_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] pc_wb_i,
  input  logic                            wb_delay_slot_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wb_lsu_adr_i,
  input  logic [15:0]                     sr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] epcr_i,
  input  logic                            fetch_ack_i,
  output logic                            pipeline_flush_o,
  output logic                            fetch_redirect_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] fetch_target_o,
  output logic                            epcr_we_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] epcr_dat_o,
  output logic                            eear_we_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] eear_dat_o,
  output logic                            esr_we_o,
  output logic                            sr_except_o,
  output logic                            sr_restore_o,
  output logic                            busy_o
);

  localparam int unsigned OW = OPTION_OPERAND_WIDTH;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t        state;
  logic          except_any;
  logic [11:0]   vec_off;
  logic          sel_data;
  logic          sel_syscall;
  logic [OW-1:0] vector;
  logic [OW-1:0] epcr_next;
  logic [OW-1:0] eear_next;

  // ESR data comes straight from SR in the SPR unit; only the strobe is generated here
  logic unused_sr;
  assign unused_sr = ^sr_i;

  assign except_any = wb_excepts_en_i &
                      (wb_except_ibus_err_i   | wb_except_ipagefault_i | wb_except_itlb_miss_i |
                       wb_except_ibus_align_i | wb_except_illegal_i    | wb_except_syscall_i   |
                       wb_except_trap_i       | wb_except_dbus_i       | wb_except_dpagefault_i |
                       wb_except_dtlb_miss_i  | wb_except_align_i);

  // Fixed-priority vector selection
  always_comb begin
    vec_off     = 12'h000;
    sel_data    = 1'b0;
    sel_syscall = 1'b0;
    if (wb_except_ibus_err_i) begin
      vec_off = 12'h200;
    end else if (wb_except_itlb_miss_i) begin
      vec_off = 12'hA00;
    end else if (wb_except_ipagefault_i) begin
      vec_off = 12'h400;
    end else if (wb_except_ibus_align_i) begin
      vec_off = 12'h600;
    end else if (wb_except_illegal_i) begin
      vec_off = 12'h700;
    end else if (wb_except_align_i) begin
      vec_off  = 12'h600;
      sel_data = 1'b1;
    end else if (wb_except_dtlb_miss_i) begin
      vec_off  = 12'h900;
      sel_data = 1'b1;
    end else if (wb_except_dpagefault_i) begin
      vec_off  = 12'h300;
      sel_data = 1'b1;
    end else if (wb_except_syscall_i) begin
      vec_off     = 12'hC00;
      sel_syscall = 1'b1;
    end else if (wb_except_trap_i) begin
      vec_off = 12'hE00;
    end else if (wb_except_dbus_i) begin
      vec_off  = 12'h200;
      sel_data = 1'b1;
    end
  end

  assign vector    = OPTION_EXCEPT_BASE + OW'(vec_off);
  assign epcr_next = wb_delay_slot_i ? (pc_wb_i - OW'(4)) :
                     sel_syscall     ? (pc_wb_i + OW'(4)) : pc_wb_i;
  assign eear_next = sel_data ? wb_lsu_adr_i : pc_wb_i;

  // Control FSM; strobes default low so every one is a single-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      pipeline_flush_o <= 1'b0;
      fetch_redirect_o <= 1'b0;
      fetch_target_o   <= '0;
      epcr_we_o        <= 1'b0;
      epcr_dat_o       <= '0;
      eear_we_o        <= 1'b0;
      eear_dat_o       <= '0;
      esr_we_o         <= 1'b0;
      sr_except_o      <= 1'b0;
      sr_restore_o     <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      pipeline_flush_o <= 1'b0;
      epcr_we_o        <= 1'b0;
      eear_we_o        <= 1'b0;
      esr_we_o         <= 1'b0;
      sr_except_o      <= 1'b0;
      sr_restore_o     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (except_any) begin
            state            <= FLUSH;
            busy_o           <= 1'b1;
            pipeline_flush_o <= 1'b1;
            epcr_we_o        <= 1'b1;
            eear_we_o        <= 1'b1;
            esr_we_o         <= 1'b1;
            sr_except_o      <= 1'b1;
            fetch_target_o   <= vector;
            epcr_dat_o       <= epcr_next;
            eear_dat_o       <= eear_next;
          end else if (wb_op_rfe_i) begin
            state            <= FLUSH;
            busy_o           <= 1'b1;
            pipeline_flush_o <= 1'b1;
            sr_restore_o     <= 1'b1;
            fetch_target_o   <= epcr_i;
          end
        end
        FLUSH: begin
          state            <= REDIRECT;
          fetch_redirect_o <= 1'b1;
        end
        REDIRECT: begin
          if (fetch_ack_i) begin
            state            <= IDLE;
            fetch_redirect_o <= 1'b0;
            busy_o           <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          fetch_redirect_o <= 1'b0;
          busy_o           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mor1kx_except_ctrl_marocchino.sv
// Directed testbench for the MAROCCHINO writeback exception/RFE controller.
module tb_mor1kx_except_ctrl_marocchino;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] exc;  // 0 ibus_err,1 itlb,2 ipf,3 ibus_align,4 illegal,5 align,6 dtlb,7 dpf,8 sys,9 trap,10 dbus
  logic        en, rfe, ds, ack;
  logic [31:0] pc, lsu_adr, epcr_in;
  logic [15:0] sr;

  logic        pipeline_flush_o, fetch_redirect_o, epcr_we_o, eear_we_o;
  logic        esr_we_o, sr_except_o, sr_restore_o, busy_o;
  logic [31:0] fetch_target_o, epcr_dat_o, eear_dat_o;

  int checks = 0;
  int passed = 0;

  // {flush, redirect, epcr_we, eear_we, esr_we, sr_except, sr_restore, busy}
  wire [7:0] strb = {pipeline_flush_o, fetch_redirect_o, epcr_we_o, eear_we_o,
                     esr_we_o, sr_except_o, sr_restore_o, busy_o};
  localparam logic [7:0] S_IDLE  = 8'b0000_0000;
  localparam logic [7:0] S_FEXC  = 8'b1011_1101;
  localparam logic [7:0] S_FRFE  = 8'b1000_0011;
  localparam logic [7:0] S_REDIR = 8'b0100_0001;

  always #5 clk = ~clk;

  mor1kx_except_ctrl_marocchino #(
    .OPTION_OPERAND_WIDTH(32),
    .OPTION_EXCEPT_BASE  (32'h0)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .wb_except_ibus_err_i  (exc[0]),
    .wb_except_itlb_miss_i (exc[1]),
    .wb_except_ipagefault_i(exc[2]),
    .wb_except_ibus_align_i(exc[3]),
    .wb_except_illegal_i   (exc[4]),
    .wb_except_align_i     (exc[5]),
    .wb_except_dtlb_miss_i (exc[6]),
    .wb_except_dpagefault_i(exc[7]),
    .wb_except_syscall_i   (exc[8]),
    .wb_except_trap_i      (exc[9]),
    .wb_except_dbus_i      (exc[10]),
    .wb_excepts_en_i       (en),
    .wb_op_rfe_i           (rfe),
    .pc_wb_i               (pc),
    .wb_delay_slot_i       (ds),
    .wb_lsu_adr_i          (lsu_adr),
    .sr_i                  (sr),
    .epcr_i                (epcr_in),
    .fetch_ack_i           (ack),
    .pipeline_flush_o      (pipeline_flush_o),
    .fetch_redirect_o      (fetch_redirect_o),
    .fetch_target_o        (fetch_target_o),
    .epcr_we_o             (epcr_we_o),
    .epcr_dat_o            (epcr_dat_o),
    .eear_we_o             (eear_we_o),
    .eear_dat_o            (eear_dat_o),
    .esr_we_o              (esr_we_o),
    .sr_except_o           (sr_except_o),
    .sr_restore_o          (sr_restore_o),
    .busy_o                (busy_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exc = '0; en = 1'b0; rfe = 1'b0; ds = 1'b0; ack = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    pc = '0; lsu_adr = '0; epcr_in = '0; sr = 16'h8001;
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (strb !== S_IDLE) $display("FAIL reset_strobes got %b exp %b", strb, S_IDLE); else passed++;
    checks++; if (fetch_target_o !== 32'h0) $display("FAIL reset_target got %h exp 0", fetch_target_o); else passed++;
    checks++; if ({epcr_dat_o, eear_dat_o} !== 64'h0) $display("FAIL reset_data got %h/%h exp 0/0", epcr_dat_o, eear_dat_o); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_illegal();
    exc = 11'h010; en = 1'b1; pc = 32'h1000;
    tick();
    clear_inputs();
    checks++; if (strb !== S_FEXC) $display("FAIL ill_flush got %b exp %b", strb, S_FEXC); else passed++;
    checks++; if (epcr_dat_o !== 32'h1000) $display("FAIL ill_epcr got %h exp 00001000", epcr_dat_o); else passed++;
    checks++; if (eear_dat_o !== 32'h1000) $display("FAIL ill_eear got %h exp 00001000", eear_dat_o); else passed++;
    tick();
    checks++; if (strb !== S_REDIR) $display("FAIL ill_redir got %b exp %b", strb, S_REDIR); else passed++;
    checks++; if (fetch_target_o !== 32'h700) $display("FAIL ill_target got %h exp 00000700", fetch_target_o); else passed++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (strb !== S_IDLE) $display("FAIL ill_idle got %b exp %b", strb, S_IDLE); else passed++;
  endtask

  task automatic test_syscall();
    logic [31:0] exp_epcr;
    for (int d = 0; d < 2; d++) begin
      exp_epcr = (d == 1) ? 32'h1FFC : 32'h2004;
      exc = 11'h100; en = 1'b1; pc = 32'h2000; ds = (d == 1);
      tick();
      clear_inputs();
      checks++; if (epcr_dat_o !== exp_epcr) $display("FAIL sys_epcr ds=%0d got %h exp %h", d, epcr_dat_o, exp_epcr); else passed++;
      tick();
      checks++; if (fetch_target_o !== 32'hC00) $display("FAIL sys_target ds=%0d got %h exp 00000C00", d, fetch_target_o); else passed++;
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
  endtask

  task automatic test_data_pair();
    exc = 11'h440; en = 1'b1; pc = 32'h4000; lsu_adr = 32'hDEAD0000;
    tick();
    clear_inputs();
    checks++; if (strb !== S_FEXC) $display("FAIL dpair_flush got %b exp %b", strb, S_FEXC); else passed++;
    checks++; if (eear_dat_o !== 32'hDEAD0000) $display("FAIL dpair_eear got %h exp DEAD0000", eear_dat_o); else passed++;
    tick();
    checks++; if (strb !== S_REDIR) $display("FAIL dpair_single_flush got %b exp %b", strb, S_REDIR); else passed++;
    checks++; if (fetch_target_o !== 32'h900) $display("FAIL dpair_target got %h exp 00000900", fetch_target_o); else passed++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_rfe();
    rfe = 1'b1; epcr_in = 32'h3000;
    tick();
    clear_inputs();
    checks++; if (strb !== S_FRFE) $display("FAIL rfe_flush got %b exp %b", strb, S_FRFE); else passed++;
    tick();
    checks++; if (fetch_target_o !== 32'h3000) $display("FAIL rfe_target got %h exp 00003000", fetch_target_o); else passed++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    rfe = 1'b1; exc = 11'h200; en = 1'b1; pc = 32'h5000;
    tick();
    clear_inputs();
    checks++; if (strb !== S_FEXC) $display("FAIL rfe_trap_flush got %b exp %b", strb, S_FEXC); else passed++;
    tick();
    checks++; if (fetch_target_o !== 32'hE00) $display("FAIL rfe_trap_target got %h exp 00000E00", fetch_target_o); else passed++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_priority();
    logic [31:0] vecs [11];
    logic [31:0] exp_eear;
    vecs = '{32'h200, 32'hA00, 32'h400, 32'h600, 32'h700, 32'h600,
             32'h900, 32'h300, 32'hC00, 32'hE00, 32'h200};
    pc = 32'h0000_8000; lsu_adr = 32'h1234_5678;
    for (int i = 0; i < 11; i++) begin
      exp_eear = (i == 5 || i == 6 || i == 7 || i == 10) ? lsu_adr : pc;
      exc = 11'h7FF << i; en = 1'b1;
      tick();
      clear_inputs();
      checks++; if (eear_dat_o !== exp_eear) $display("FAIL prio_eear[%0d] got %h exp %h", i, eear_dat_o, exp_eear); else passed++;
      tick();
      checks++; if (fetch_target_o !== vecs[i]) $display("FAIL prio_target[%0d] got %h exp %h", i, fetch_target_o, vecs[i]); else passed++;
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
  endtask

  task automatic test_stall();
    exc = 11'h010; en = 1'b1; pc = 32'h6000;
    tick();
    clear_inputs();
    tick();
    exc = 11'h100; en = 1'b1; rfe = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (strb !== S_REDIR) $display("FAIL stall_strb[%0d] got %b exp %b", c, strb, S_REDIR); else passed++;
      checks++; if (fetch_target_o !== 32'h700) $display("FAIL stall_target[%0d] got %h exp 00000700", c, fetch_target_o); else passed++;
    end
    clear_inputs();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (strb !== S_IDLE) $display("FAIL stall_idle got %b exp %b", strb, S_IDLE); else passed++;
    tick();
    checks++; if (strb !== S_IDLE) $display("FAIL stall_no_replay got %b exp %b", strb, S_IDLE); else passed++;
  endtask

  task automatic test_reset_abort();
    exc = 11'h010; en = 1'b1; pc = 32'h7000;
    tick();
    clear_inputs();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (strb !== S_IDLE) $display("FAIL abort_strb got %b exp %b", strb, S_IDLE); else passed++;
    checks++; if (fetch_target_o !== 32'h0) $display("FAIL abort_target got %h exp 0", fetch_target_o); else passed++;
    tick();
    rst_n = 1'b1;
    exc = 11'h010; en = 1'b0; pc = 32'h7100;
    tick();
    checks++; if (strb !== S_IDLE) $display("FAIL en0_strb got %b exp %b", strb, S_IDLE); else passed++;
    tick();
    checks++; if ({strb, fetch_target_o} !== 40'h0) $display("FAIL en0_quiet got %b/%h exp 0/0", strb, fetch_target_o); else passed++;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_syscall();
    test_data_pair();
    test_rfe();
    test_priority();
    test_stall();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
